// File: rtl/otter_hazard_unit.sv
// Hazard and forwarding controller for the pipelined OTTER core.
// A scoreboard of in-flight destinations drives forwarding selects, load-use stalls and branch flushes.
module otter_hazard_unit #(
    parameter int DEPTH        = 3,
    parameter int LOAD_AVAIL   = 2,
    parameter int REDIRECT_LAT = 0,
    parameter int CNT_W        = 16,
    localparam int SW          = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_rd_used,
    input  logic             i_id_is_load,
    input  logic             i_br_taken,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_flush_if,
    output logic             o_flush_id,
    output logic             o_bubble_ex,
    output logic [SW-1:0]    o_fwd_a_sel,
    output logic [SW-1:0]    o_fwd_b_sel,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int FW = (REDIRECT_LAT > 0) ? $clog2(REDIRECT_LAT + 1) : 1;
    localparam logic [SW-1:0] LOAD_AVAIL_SEL = SW'(LOAD_AVAIL);

    logic                  r_active;
    logic [DEPTH:1]        r_sb_valid;
    logic [DEPTH:1][4:0]   r_sb_rd;
    logic [DEPTH:1]        r_sb_load;
    logic [FW-1:0]         r_flush_cnt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_evt_cnt;

    logic [SW-1:0]         w_a_sel;
    logic [SW-1:0]         w_b_sel;
    logic                  w_a_load;
    logic                  w_b_load;
    logic                  w_stall_raw;
    logic                  w_stall;
    logic                  w_flush;
    logic                  w_kill;
    logic                  w_new_valid;

    // Descending scan so the youngest (smallest k) matching writer wins.
    always_comb begin
        w_a_sel  = '0;
        w_a_load = 1'b0;
        w_b_sel  = '0;
        w_b_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_id_rs1_used && (i_id_rs1 != 5'd0) && r_sb_valid[k] && (r_sb_rd[k] == i_id_rs1)) begin
                w_a_sel  = SW'(k);
                w_a_load = r_sb_load[k];
            end
            if (i_id_rs2_used && (i_id_rs2 != 5'd0) && r_sb_valid[k] && (r_sb_rd[k] == i_id_rs2)) begin
                w_b_sel  = SW'(k);
                w_b_load = r_sb_load[k];
            end
        end
    end

    assign w_stall_raw = r_active && ((w_a_load && (w_a_sel < LOAD_AVAIL_SEL)) ||
                                      (w_b_load && (w_b_sel < LOAD_AVAIL_SEL)));
    assign w_flush     = r_active && (i_br_taken || (r_flush_cnt != '0));
    assign w_stall     = w_stall_raw && !w_flush;
    assign w_kill      = w_stall || w_flush;
    assign w_new_valid = i_id_valid && i_id_rd_used && (i_id_rd != 5'd0) && !w_kill;

    assign o_stall_if  = w_stall;
    assign o_stall_id  = w_stall;
    assign o_flush_if  = w_flush;
    assign o_flush_id  = w_flush;
    assign o_bubble_ex = w_kill;
    assign o_fwd_a_sel = (r_active && !w_stall) ? w_a_sel : '0;
    assign o_fwd_b_sel = (r_active && !w_stall) ? w_b_sel : '0;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_evt_cnt;

    // r_active keeps every output quiet for the first cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active        <= 1'b0;
            r_sb_valid      <= '0;
            r_sb_rd         <= '0;
            r_sb_load       <= '0;
            r_flush_cnt     <= '0;
            r_stall_cnt     <= '0;
            r_flush_evt_cnt <= '0;
        end else begin
            r_active   <= 1'b1;
            r_sb_valid <= {r_sb_valid[DEPTH-1:1], w_new_valid};
            r_sb_rd    <= {r_sb_rd[DEPTH-1:1], i_id_rd};
            r_sb_load  <= {r_sb_load[DEPTH-1:1], i_id_is_load};

            if (r_active && i_br_taken) begin
                r_flush_cnt <= FW'(REDIRECT_LAT);
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (r_active && i_br_taken && (r_flush_evt_cnt != '1)) begin
                r_flush_evt_cnt <= r_flush_evt_cnt + 1'b1;
            end
        end
    end

endmodule
